// File: rtl/uart_echo_fifo.sv
// uart_echo_fifo: UART loopback engine. Characters arriving on rx_phy are
// received, checked for framing and parity, buffered in a FIFO and echoed
// back out on tx_phy with the same framing.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   rx_phy     serial input, idle high, asynchronous to clk
//   tx_hold    1 = do not start a new TX character (one in flight completes)
//   err_clear  pulse, clears the sticky error flags (a new error wins)
//   tx_phy     serial output, idle high, registered
//   rx_busy    RX FSM not idle
//   tx_busy    TX FSM not idle
//   fifo_count FIFO occupancy, registered
//   overflow   sticky: valid character dropped, FIFO full
//   parity_err sticky: character received with bad parity
//   frame_err  sticky: stop bit sampled low
module uart_echo_fifo #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              rx_phy,
  input  logic                              tx_hold,
  input  logic                              err_clear,
  output logic                              tx_phy,
  output logic                              rx_busy,
  output logic                              tx_busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
  output logic                              overflow,
  output logic                              parity_err,
  output logic                              frame_err
);

  localparam int   CNT_W   = $clog2(CLKS_PER_BIT);
  localparam int   BIT_W   = $clog2(DATA_BITS);
  localparam int   AW      = $clog2(FIFO_DEPTH);
  localparam int   CW      = $clog2(FIFO_DEPTH + 1);
  localparam bit   PAR_EN  = (PARITY != 0);
  // Odd parity is the inverse of the data XOR.
  localparam logic PAR_INV = (PARITY == 1);

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_IDLE
  } rx_state_t;

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_t;

  // ---------------------------------------------------------------------
  // Input synchroniser and falling-edge detect
  // ---------------------------------------------------------------------
  logic sync1, sync2, rx_prev;
  logic rx_s, rx_fall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      sync1   <= rx_phy;
      sync2   <= sync1;
      rx_prev <= sync2;
    end
  end

  always_comb begin
    rx_s    = sync2;
    rx_fall = rx_prev & ~sync2;
  end

  // ---------------------------------------------------------------------
  // RX FSM
  // ---------------------------------------------------------------------
  rx_state_t              rx_state, rx_next;
  logic [CNT_W-1:0]       rx_clk_cnt;
  logic [BIT_W-1:0]       rx_bit_cnt;
  logic [DATA_BITS-1:0]   rx_shift;
  logic                   rx_par_bit;
  logic                   rx_tick;
  logic                   stop_sample, par_ok;
  logic                   push, par_evt, frame_evt;

  // The start bit is sampled half a bit in; every later sample is a full
  // bit period after the previous one, landing near mid-bit.
  always_comb begin
    if (rx_state == RX_START)
      rx_tick = (rx_clk_cnt == CNT_W'(CLKS_PER_BIT / 2 - 1));
    else
      rx_tick = (rx_clk_cnt == CNT_W'(CLKS_PER_BIT - 1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rx_state <= RX_IDLE;
    else      rx_state <= rx_next;
  end

  always_comb begin
    rx_next = rx_state;
    unique case (rx_state)
      RX_IDLE:      if (rx_fall) rx_next = RX_START;
      RX_START:     if (rx_tick) rx_next = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:
        if (rx_tick && rx_bit_cnt == BIT_W'(DATA_BITS - 1))
          rx_next = PAR_EN ? RX_PARITY : RX_STOP;
      RX_PARITY:    if (rx_tick) rx_next = RX_STOP;
      RX_STOP:      if (rx_tick) rx_next = rx_s ? RX_IDLE : RX_WAIT_IDLE;
      RX_WAIT_IDLE: if (rx_s) rx_next = RX_IDLE;
      default:      rx_next = RX_IDLE;
    endcase
  end

  always_comb begin
    rx_busy     = (rx_state != RX_IDLE);
    stop_sample = (rx_state == RX_STOP) && rx_tick;
    par_ok      = !PAR_EN || (rx_par_bit == ((^rx_shift) ^ PAR_INV));
    push        = stop_sample && rx_s && par_ok;
    par_evt     = stop_sample && rx_s && !par_ok;
    frame_evt   = stop_sample && !rx_s;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_clk_cnt <= '0;
      rx_bit_cnt <= '0;
      rx_shift   <= '0;
      rx_par_bit <= 1'b0;
    end else begin
      if (rx_state == RX_IDLE || rx_state == RX_WAIT_IDLE || rx_tick)
        rx_clk_cnt <= '0;
      else
        rx_clk_cnt <= rx_clk_cnt + 1'b1;

      if (rx_state == RX_IDLE)
        rx_bit_cnt <= '0;
      else if (rx_state == RX_DATA && rx_tick)
        rx_bit_cnt <= rx_bit_cnt + 1'b1;

      // LSB first: each new bit enters at the top and shifts down.
      if (rx_state == RX_DATA && rx_tick)
        rx_shift <= {rx_s, rx_shift[DATA_BITS-1:1]};

      if (rx_state == RX_PARITY && rx_tick)
        rx_par_bit <= rx_s;
    end
  end

  // ---------------------------------------------------------------------
  // Echo FIFO
  // ---------------------------------------------------------------------
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [DATA_BITS-1:0] head;
  logic                 pop, push_ok;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  always_comb begin
    head    = mem[rd_ptr];
    push_ok = push && ((fifo_count < CW'(FIFO_DEPTH)) || pop);
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= rx_shift;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      unique case ({push_ok, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // TX FSM
  // ---------------------------------------------------------------------
  tx_state_t            tx_state, tx_next;
  logic [CNT_W-1:0]     tx_clk_cnt;
  logic [BIT_W-1:0]     tx_bit_cnt;
  logic [DATA_BITS-1:0] tx_shift;
  logic                 tx_par;
  logic                 tx_tick, tx_last;

  always_comb begin
    tx_tick = (tx_clk_cnt == CNT_W'(CLKS_PER_BIT - 1));
    tx_last = (tx_bit_cnt == BIT_W'(DATA_BITS - 1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tx_state <= TX_IDLE;
    else      tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    unique case (tx_state)
      TX_IDLE:   if (pop) tx_next = TX_START;
      TX_START:  if (tx_tick) tx_next = TX_DATA;
      TX_DATA:   if (tx_tick && tx_last) tx_next = PAR_EN ? TX_PARITY : TX_STOP;
      TX_PARITY: if (tx_tick) tx_next = TX_STOP;
      TX_STOP:   if (tx_tick) tx_next = TX_IDLE;
      default:   tx_next = TX_IDLE;
    endcase
  end

  always_comb begin
    tx_busy = (tx_state != TX_IDLE);
    pop     = (tx_state == TX_IDLE) && (fifo_count != '0) && !tx_hold;
  end

  // tx_phy is loaded with the level of the bit being entered, so each level
  // appears the cycle after the transition that selects it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_clk_cnt <= '0;
      tx_bit_cnt <= '0;
      tx_shift   <= '0;
      tx_par     <= 1'b0;
      tx_phy     <= 1'b1;
    end else begin
      if (tx_state == TX_IDLE || tx_tick)
        tx_clk_cnt <= '0;
      else
        tx_clk_cnt <= tx_clk_cnt + 1'b1;

      if (tx_state != TX_DATA)
        tx_bit_cnt <= '0;
      else if (tx_tick)
        tx_bit_cnt <= tx_bit_cnt + 1'b1;

      if (pop) begin
        tx_shift <= head;
        tx_par   <= (^head) ^ PAR_INV;
      end else if (tx_state == TX_DATA && tx_tick) begin
        tx_shift <= tx_shift >> 1;
      end

      if (pop) begin
        tx_phy <= 1'b0;
      end else if (tx_tick) begin
        unique case (tx_state)
          TX_START: tx_phy <= tx_shift[0];
          TX_DATA:
            if (tx_last) tx_phy <= PAR_EN ? tx_par : 1'b1;
            else         tx_phy <= tx_shift[1];
          default:  tx_phy <= 1'b1;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------
  // Sticky error flags (a new event takes priority over err_clear)
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      if (push && !push_ok) overflow <= 1'b1;
      else if (err_clear)   overflow <= 1'b0;

      if (par_evt)          parity_err <= 1'b1;
      else if (err_clear)   parity_err <= 1'b0;

      if (frame_evt)        frame_err <= 1'b1;
      else if (err_clear)   frame_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_echo_fifo.sv
// Testbench for uart_echo_fifo: two instances (8N1 and 7E1, CLKS_PER_BIT=4,
// FIFO_DEPTH=4). Expected echoes are queued as characters are sent and a
// monitor per instance decodes tx_phy and checks against the queue.
module tb_uart_echo_fifo;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] rxs, hold, clr;

  logic       tx_a, rxb_a, txb_a, ov_a, pe_a, fe_a;
  logic       tx_b, rxb_b, txb_b, ov_b, pe_b, fe_b;
  logic [2:0] cnt_a, cnt_b;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [8:0] q0[$];
  logic [8:0] q1[$];

  int lat_ref[2];
  bit lat_chk[2];
  bit btb_chk[2];
  int prev_start[2];
  bit holding[2];
  int held[2];
  bit exp_pe[2], exp_fe[2], exp_ov[2];

  uart_echo_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .FIFO_DEPTH(DEPTH)) dut_a (
    .clk(clk), .rst(rst), .rx_phy(rxs[0]), .tx_hold(hold[0]), .err_clear(clr[0]),
    .tx_phy(tx_a), .rx_busy(rxb_a), .tx_busy(txb_a), .fifo_count(cnt_a),
    .overflow(ov_a), .parity_err(pe_a), .frame_err(fe_a));

  uart_echo_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .FIFO_DEPTH(DEPTH)) dut_b (
    .clk(clk), .rst(rst), .rx_phy(rxs[1]), .tx_hold(hold[1]), .err_clear(clr[1]),
    .tx_phy(tx_b), .rx_busy(rxb_b), .tx_busy(txb_b), .fifo_count(cnt_b),
    .overflow(ov_b), .parity_err(pe_b), .frame_err(fe_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int db_of(input int i);  return (i == 0) ? 8 : 7; endfunction
  function automatic int par_of(input int i); return (i == 0) ? 0 : 2; endfunction
  function automatic logic get_tx(input int i);  return (i == 0) ? tx_a  : tx_b;  endfunction
  function automatic logic get_txb(input int i); return (i == 0) ? txb_a : txb_b; endfunction
  function automatic logic get_rxb(input int i); return (i == 0) ? rxb_a : rxb_b; endfunction
  function automatic logic get_ov(input int i);  return (i == 0) ? ov_a  : ov_b;  endfunction
  function automatic logic get_pe(input int i);  return (i == 0) ? pe_a  : pe_b;  endfunction
  function automatic logic get_fe(input int i);  return (i == 0) ? fe_a  : fe_b;  endfunction
  function automatic int   get_cnt(input int i); return (i == 0) ? int'(cnt_a) : int'(cnt_b); endfunction
  function automatic int   qsize(input int i);   return (i == 0) ? q0.size() : q1.size(); endfunction

  function automatic logic [8:0] qpop(input int i);
    if (i == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  // Parity bit as the line should carry it: XOR of the data bits, inverted for odd.
  function automatic logic exp_par(input int i, input logic [8:0] d);
    logic x = 1'b0;
    for (int b = 0; b < db_of(i); b++) x ^= d[b];
    return (par_of(i) == 1) ? ~x : x;
  endfunction

  task automatic chk(input string name, input int got, input int expv);
    total++;
    if (got != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, expv);
    end
  endtask

  // Drive one frame on rx line i, then update the reference model.
  task automatic send(input int i, input logic [8:0] data, input bit bad_par,
                      input bit bad_stop, input int extra);
    logic [8:0] d;
    d = data & ((9'h1 << db_of(i)) - 9'h1);
    lat_ref[i] = cyc;
    rxs[i] = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int b = 0; b < db_of(i); b++) begin
      rxs[i] = d[b];
      repeat (CPB) @(negedge clk);
    end
    if (par_of(i) != 0) begin
      rxs[i] = exp_par(i, d) ^ bad_par;
      repeat (CPB) @(negedge clk);
    end
    rxs[i] = ~bad_stop;
    repeat (CPB) @(negedge clk);
    if (bad_stop) begin
      repeat (extra) @(negedge clk);
      rxs[i] = 1'b1;
    end
    if (bad_stop) exp_fe[i] = 1'b1;
    else if (par_of(i) != 0 && bad_par) exp_pe[i] = 1'b1;
    else if (holding[i] && held[i] >= DEPTH) exp_ov[i] = 1'b1;
    else begin
      if (holding[i]) held[i]++;
      if (i == 0) q0.push_back(d); else q1.push_back(d);
    end
  endtask

  task automatic wait_idle(input int i);
    int n = 0;
    while ((qsize(i) != 0 || get_txb(i) || get_rxb(i)) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    chk($sformatf("drain_timeout[%0d]", i), (n < 2000) ? 1 : 0, 1);
  endtask

  task automatic check_flags(input int i, input string tag);
    chk($sformatf("%s_overflow[%0d]", tag, i),   get_ov(i), exp_ov[i]);
    chk($sformatf("%s_parity_err[%0d]", tag, i), get_pe(i), exp_pe[i]);
    chk($sformatf("%s_frame_err[%0d]", tag, i),  get_fe(i), exp_fe[i]);
  endtask

  task automatic clear_flags(input int i);
    clr[i] = 1'b1;
    @(negedge clk);
    clr[i] = 1'b0;
    exp_pe[i] = 1'b0; exp_fe[i] = 1'b0; exp_ov[i] = 1'b0;
    @(negedge clk);
  endtask

  // Monitor: decodes each tx frame at mid-bit and compares with the queue.
  task automatic mon(input int i);
    forever begin
      @(negedge clk);
      if (rst && get_tx(i) == 1'b0) begin
        int         t0 = cyc;
        bit         abort = 1'b0;
        logic       st, pb, sb;
        logic [8:0] d = '0;
        logic [8:0] e;
        repeat (CPB / 2) @(negedge clk);
        st = get_tx(i);
        if (!rst) abort = 1'b1;
        for (int b = 0; b < db_of(i); b++) begin
          repeat (CPB) @(negedge clk);
          d[b] = get_tx(i);
          if (!rst) abort = 1'b1;
        end
        pb = 1'b0;
        if (par_of(i) != 0) begin
          repeat (CPB) @(negedge clk);
          pb = get_tx(i);
          if (!rst) abort = 1'b1;
        end
        repeat (CPB) @(negedge clk);
        sb = get_tx(i);
        if (!rst) abort = 1'b1;
        if (!abort) begin
          if (qsize(i) == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_echo[%0d]: got 0x%0h expected no frame", i, d);
          end else begin
            e = qpop(i);
            chk($sformatf("echo_data[%0d]", i), d, e);
            chk($sformatf("echo_frame[%0d]", i), {st, pb, sb},
                {1'b0, (par_of(i) != 0) ? exp_par(i, e) : 1'b0, 1'b1});
          end
          if (lat_chk[i]) begin
            chk($sformatf("start_latency[%0d]", i), t0 - lat_ref[i], 42);
            lat_chk[i] = 1'b0;
          end
          if (btb_chk[i]) begin
            if (prev_start[i] >= 0)
              chk($sformatf("back_to_back[%0d]", i), t0 - prev_start[i], 41);
            prev_start[i] = t0;
          end
        end
      end
    end
  endtask

  initial mon(0);
  initial mon(1);

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bit seen;
    rst = 1'b0; rxs = 2'b11; hold = 2'b00; clr = 2'b00;
    for (int i = 0; i < 2; i++) begin
      lat_chk[i] = 0; btb_chk[i] = 0; prev_start[i] = -1; holding[i] = 0; held[i] = 0;
      exp_pe[i] = 0; exp_fe[i] = 0; exp_ov[i] = 0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("reset_tx_phy[%0d]", i), get_tx(i), 1);
      chk($sformatf("reset_busy[%0d]", i), {get_rxb(i), get_txb(i)}, 0);
      chk($sformatf("reset_count[%0d]", i), get_cnt(i), 0);
      check_flags(i, "reset");
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Single character with start-bit latency.
    lat_chk[0] = 1'b1;
    send(0, 9'hA5, 0, 0, 0);
    wait_idle(0);
    chk("single_count", get_cnt(0), 0);
    check_flags(0, "single");

    // Hold back-pressure and overflow, then back-to-back drain.
    hold[0] = 1'b1; holding[0] = 1'b1; held[0] = 0;
    for (int k = 1; k <= 6; k++) begin
      send(0, 9'(k), 0, 0, 0);
      repeat (2) @(negedge clk);
    end
    chk("hold_count", get_cnt(0), held[0]);
    chk("hold_overflow", get_ov(0), exp_ov[0]);
    btb_chk[0] = 1'b1; prev_start[0] = -1;
    hold[0] = 1'b0; holding[0] = 1'b0;
    wait_idle(0);
    btb_chk[0] = 1'b0;
    chk("drain_count", get_cnt(0), 0);
    clear_flags(0);
    check_flags(0, "ovf_clear");

    // Even parity, 7 data bits.
    lat_chk[1] = 1'b1;
    send(1, 9'h41, 0, 0, 0);
    wait_idle(1);
    send(1, 9'h41, 1, 0, 0);
    wait_idle(1);
    check_flags(1, "bad_parity");
    clear_flags(1);
    check_flags(1, "parity_clear");

    // Framing error followed by a long break, then a good character.
    send(0, 9'h55, 0, 1, 30);
    repeat (4) @(negedge clk);
    check_flags(0, "frame");
    send(0, 9'h3C, 0, 0, 0);
    wait_idle(0);
    check_flags(0, "after_frame");
    clear_flags(0);
    check_flags(0, "frame_clear");

    // One-cycle glitch: a false start.
    rxs[0] = 1'b0;
    @(negedge clk);
    rxs[0] = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (get_rxb(0)) seen = 1'b1;
    end
    chk("false_start_busy", seen, 1);
    repeat (20) @(negedge clk);
    chk("false_start_idle", get_rxb(0), 0);
    chk("false_start_count", get_cnt(0), 0);
    check_flags(0, "false_start");

    // Reset during TX data bit 3.
    send(0, 9'h33, 0, 0, 0);
    repeat (19) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk("midreset_tx_phy", get_tx(0), 1);
    chk("midreset_tx_busy", get_txb(0), 0);
    chk("midreset_count", get_cnt(0), 0);
    q0.delete();
    for (int i = 0; i < 2; i++) begin
      exp_pe[i] = 0; exp_fe[i] = 0; exp_ov[i] = 0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    send(0, 9'h7E, 0, 0, 0);
    wait_idle(0);
    check_flags(0, "post_reset");

    // Randomised traffic on both instances.
    for (int i = 0; i < 2; i++) begin
      clear_flags(i);
      for (int k = 0; k < 12; k++) begin
        int r;
        r = $urandom_range(0, 5);
        send(i, 9'($urandom), (r == 0), (r == 1), $urandom_range(0, 8));
        repeat ($urandom_range(1, 6)) @(negedge clk);
      end
      wait_idle(i);
      chk($sformatf("random_count[%0d]", i), get_cnt(i), 0);
      check_flags(i, "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
